// File: rtl/inst_translate_pkg.sv
// Shared opcode/funct constants, decode class/ALU encodings and the decoded
// instruction bundle used by the MIPS instruction translator.
package inst_translate_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [4:0] RA_REG = 5'd31;

  typedef enum logic [2:0] {
    IT_R       = 3'd0,
    IT_IALU    = 3'd1,
    IT_LOAD    = 3'd2,
    IT_STORE   = 3'd3,
    IT_BRANCH  = 3'd4,
    IT_JUMP    = 3'd5,
    IT_ILLEGAL = 3'd7
  } inst_type_e;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_NOR = 4'd6,
    ALU_SLT = 4'd7,
    ALU_SLL = 4'd8,
    ALU_SRL = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm32;
    logic [25:0] j_addr;
    inst_type_e  inst_type;
    alu_op_e     alu_op;
    logic        reg_write;
    logic        illegal;
  } decode_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/inst_translate_if.sv
// Handshake and decode-output bundle between fetch, translator and consumer.
interface inst_translate_if #(
  parameter int CNT_W = 16
) ();
  logic             In_Valid;
  logic             In_Ready;
  logic [31:0]      Inst_Code;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [5:0]       Op;
  logic [4:0]       Rs;
  logic [4:0]       Rt;
  logic [4:0]       Rd;
  logic [4:0]       Shamt;
  logic [5:0]       Funct;
  logic [31:0]      Imm32;
  logic [25:0]      J_Addr;
  logic [2:0]       Inst_Type;
  logic [3:0]       ALU_Op;
  logic             Reg_Write;
  logic             Illegal;
  logic [CNT_W-1:0] Inst_Cnt;
  logic [CNT_W-1:0] Ill_Cnt;

  modport slave (
    input  In_Valid, Inst_Code, Out_Ready,
    output In_Ready, Out_Valid, Op, Rs, Rt, Rd, Shamt, Funct, Imm32, J_Addr,
           Inst_Type, ALU_Op, Reg_Write, Illegal, Inst_Cnt, Ill_Cnt
  );

  modport master (
    output In_Valid, Inst_Code, Out_Ready,
    input  In_Ready, Out_Valid, Op, Rs, Rt, Rd, Shamt, Funct, Imm32, J_Addr,
           Inst_Type, ALU_Op, Reg_Write, Illegal, Inst_Cnt, Ill_Cnt
  );
endinterface

// File: rtl/inst_decode_comb.sv
// Purely combinational MIPS instruction word to decode-bundle translation.
module inst_decode_comb
  import inst_translate_pkg::*;
(
  input  logic [31:0] inst_i,
  output decode_t     dec_o
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] imm16;

  assign op    = inst_i[31:26];
  assign funct = inst_i[5:0];
  assign imm16 = inst_i[15:0];

  always_comb begin
    dec_o           = '0;
    dec_o.op        = op;
    dec_o.rs        = inst_i[25:21];
    dec_o.rt        = inst_i[20:16];
    dec_o.shamt     = inst_i[10:6];
    dec_o.funct     = funct;
    dec_o.j_addr    = inst_i[25:0];
    dec_o.inst_type = IT_ILLEGAL;
    dec_o.alu_op    = ALU_NOP;

    case (op)
      OP_RTYPE: begin
        dec_o.inst_type = IT_R;
        case (funct)
          FN_ADD:  dec_o.alu_op = ALU_ADD;
          FN_SUB:  dec_o.alu_op = ALU_SUB;
          FN_AND:  dec_o.alu_op = ALU_AND;
          FN_OR:   dec_o.alu_op = ALU_OR;
          FN_XOR:  dec_o.alu_op = ALU_XOR;
          FN_NOR:  dec_o.alu_op = ALU_NOR;
          FN_SLT:  dec_o.alu_op = ALU_SLT;
          FN_SLL:  dec_o.alu_op = ALU_SLL;
          FN_SRL:  dec_o.alu_op = ALU_SRL;
          default: dec_o.inst_type = IT_ILLEGAL;
        endcase
      end
      OP_ADDI: begin
        dec_o.inst_type = IT_IALU;
        dec_o.alu_op    = ALU_ADD;
        dec_o.imm32     = sext16(imm16);
      end
      OP_SLTI: begin
        dec_o.inst_type = IT_IALU;
        dec_o.alu_op    = ALU_SLT;
        dec_o.imm32     = sext16(imm16);
      end
      OP_ANDI: begin
        dec_o.inst_type = IT_IALU;
        dec_o.alu_op    = ALU_AND;
        dec_o.imm32     = {16'h0000, imm16};
      end
      OP_ORI: begin
        dec_o.inst_type = IT_IALU;
        dec_o.alu_op    = ALU_OR;
        dec_o.imm32     = {16'h0000, imm16};
      end
      OP_XORI: begin
        dec_o.inst_type = IT_IALU;
        dec_o.alu_op    = ALU_XOR;
        dec_o.imm32     = {16'h0000, imm16};
      end
      OP_LUI: begin
        dec_o.inst_type = IT_IALU;
        dec_o.alu_op    = ALU_LUI;
        dec_o.imm32     = {imm16, 16'h0000};
      end
      OP_LW: begin
        dec_o.inst_type = IT_LOAD;
        dec_o.alu_op    = ALU_ADD;
        dec_o.imm32     = sext16(imm16);
      end
      OP_SW: begin
        dec_o.inst_type = IT_STORE;
        dec_o.alu_op    = ALU_ADD;
        dec_o.imm32     = sext16(imm16);
      end
      OP_BEQ, OP_BNE: begin
        dec_o.inst_type = IT_BRANCH;
        dec_o.alu_op    = ALU_SUB;
        dec_o.imm32     = sext16(imm16);
      end
      OP_J, OP_JAL: dec_o.inst_type = IT_JUMP;
      default: ;
    endcase

    // Destination and write-enable follow from the resolved class, so an
    // R-type with an unknown funct falls through to "no write, Rd=0".
    case (dec_o.inst_type)
      IT_R: begin
        dec_o.reg_write = 1'b1;
        dec_o.rd        = inst_i[15:11];
      end
      IT_IALU, IT_LOAD: begin
        dec_o.reg_write = 1'b1;
        dec_o.rd        = inst_i[20:16];
      end
      IT_JUMP: begin
        if (op == OP_JAL) begin
          dec_o.reg_write = 1'b1;
          dec_o.rd        = RA_REG;
        end
      end
      default: ;
    endcase

    dec_o.illegal = (dec_o.inst_type == IT_ILLEGAL);
  end

endmodule

// File: rtl/inst_translate.sv
// Registered instruction translator: one-cycle decode behind a two-entry
// (output + skid) buffer, plus delivered/illegal instruction counters.
module inst_translate
  import inst_translate_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic              Clk,
  input logic              Rst,
  inst_translate_if.slave  bus
);

  decode_t          in_dec;
  decode_t          out_q, out_d;
  decode_t          skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic             accept;
  logic             fire;

  inst_decode_comb u_decode (
    .inst_i (bus.Inst_Code),
    .dec_o  (in_dec)
  );

  assign accept = bus.In_Valid & ~skid_valid_q;
  assign fire   = out_valid_q & bus.Out_Ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;

    if (skid_valid_q) begin
      if (bus.Out_Ready) begin
        out_d        = skid_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_d = in_dec;
        end
      end
    end else if (accept) begin
      if (!out_valid_q || bus.Out_Ready) begin
        out_d       = in_dec;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = in_dec;
        skid_valid_d = 1'b1;
      end
    end else if (bus.Out_Ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    inst_cnt_d = inst_cnt_q;
    ill_cnt_d  = ill_cnt_q;
    if (fire) begin
      inst_cnt_d = inst_cnt_q + CNT_W'(1);
      if (out_q.illegal) begin
        ill_cnt_d = ill_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      inst_cnt_q   <= '0;
      ill_cnt_q    <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      inst_cnt_q   <= inst_cnt_d;
      ill_cnt_q    <= ill_cnt_d;
    end
  end

  assign bus.In_Ready  = ~skid_valid_q;
  assign bus.Out_Valid = out_valid_q;
  assign bus.Op        = out_q.op;
  assign bus.Rs        = out_q.rs;
  assign bus.Rt        = out_q.rt;
  assign bus.Rd        = out_q.rd;
  assign bus.Shamt     = out_q.shamt;
  assign bus.Funct     = out_q.funct;
  assign bus.Imm32     = out_q.imm32;
  assign bus.J_Addr    = out_q.j_addr;
  assign bus.Inst_Type = out_q.inst_type;
  assign bus.ALU_Op    = out_q.alu_op;
  assign bus.Reg_Write = out_q.reg_write;
  assign bus.Illegal   = out_q.illegal;
  assign bus.Inst_Cnt  = inst_cnt_q;
  assign bus.Ill_Cnt   = ill_cnt_q;

endmodule

// File: tb/tb_inst_translate.sv
// Bench for inst_translate: fixed decode vectors, stall/drain and reset
// sequences, and random handshake traffic against a scoreboard.
module tb_inst_translate;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_translate_if #(.CNT_W(16)) bus ();
  inst_translate_if #(.CNT_W(4))  bus4 ();

  inst_translate #(.CNT_W(16)) dut  (.Clk(clk), .Rst(rst), .bus(bus));
  inst_translate #(.CNT_W(4))  dut4 (.Clk(clk), .Rst(rst), .bus(bus4));

  // Narrow-counter copy sees identical traffic, exercising counter wrap.
  assign bus4.In_Valid  = bus.In_Valid;
  assign bus4.Inst_Code = bus.Inst_Code;
  assign bus4.Out_Ready = bus.Out_Ready;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic [25:0] ja;
    logic [2:0]  typ;
    logic [3:0]  alu;
    logic        rw, ill;
  } dec_t;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  typ;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        rw;
    logic        ill;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  dec_t sb[$];
  int   delivered = 0;
  int   ill_delivered = 0;
  vec_t tbl[13];

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic dec_t actual();
    dec_t a;
    a = '{bus.Op, bus.Rs, bus.Rt, bus.Rd, bus.Shamt, bus.Funct, bus.Imm32,
          bus.J_Addr, bus.Inst_Type, bus.ALU_Op, bus.Reg_Write, bus.Illegal};
    return a;
  endfunction

  // Reference: class/ALU/immediate from the instruction-set rules.
  function automatic dec_t model(input logic [31:0] w);
    dec_t e;
    logic [31:0] simm, zimm;
    logic        legal;
    e = '0;
    e.op = w[31:26]; e.rs = w[25:21]; e.rt = w[20:16];
    e.shamt = w[10:6]; e.funct = w[5:0]; e.ja = w[25:0];
    simm = {{16{w[15]}}, w[15:0]};
    zimm = {16'h0, w[15:0]};
    legal = 1'b1;
    case (w[31:26])
      6'h00: begin
        e.typ = 3'd0; e.rw = 1'b1; e.rd = w[15:11];
        case (w[5:0])
          6'h20: e.alu = 4'd1;  6'h22: e.alu = 4'd2;  6'h24: e.alu = 4'd3;
          6'h25: e.alu = 4'd4;  6'h26: e.alu = 4'd5;  6'h27: e.alu = 4'd6;
          6'h2A: e.alu = 4'd7;  6'h00: e.alu = 4'd8;  6'h02: e.alu = 4'd9;
          default: legal = 1'b0;
        endcase
      end
      6'h08: begin e.typ = 3'd1; e.alu = 4'd1;  e.imm = simm; e.rw = 1'b1; e.rd = w[20:16]; end
      6'h0A: begin e.typ = 3'd1; e.alu = 4'd7;  e.imm = simm; e.rw = 1'b1; e.rd = w[20:16]; end
      6'h0C: begin e.typ = 3'd1; e.alu = 4'd3;  e.imm = zimm; e.rw = 1'b1; e.rd = w[20:16]; end
      6'h0D: begin e.typ = 3'd1; e.alu = 4'd4;  e.imm = zimm; e.rw = 1'b1; e.rd = w[20:16]; end
      6'h0E: begin e.typ = 3'd1; e.alu = 4'd5;  e.imm = zimm; e.rw = 1'b1; e.rd = w[20:16]; end
      6'h0F: begin e.typ = 3'd1; e.alu = 4'd10; e.imm = zimm << 16; e.rw = 1'b1; e.rd = w[20:16]; end
      6'h23: begin e.typ = 3'd2; e.alu = 4'd1;  e.imm = simm; e.rw = 1'b1; e.rd = w[20:16]; end
      6'h2B: begin e.typ = 3'd3; e.alu = 4'd1;  e.imm = simm; end
      6'h04, 6'h05: begin e.typ = 3'd4; e.alu = 4'd2; e.imm = simm; end
      6'h02: e.typ = 3'd5;
      6'h03: begin e.typ = 3'd5; e.rw = 1'b1; e.rd = 5'd31; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.typ = 3'd7; e.alu = 4'd0; e.rw = 1'b0; e.rd = 5'd0; e.imm = '0; e.ill = 1'b1;
    end
    return e;
  endfunction

  // Immediate is only meaningful for I-format and jump classes.
  function automatic logic imm_dont_care(input logic [2:0] typ);
    return (typ == 3'd0) || (typ == 3'd7);
  endfunction

  // One clock: score the output handshake, record any input accept, advance.
  task automatic tick();
    logic acc, fire, hold;
    dec_t e, g;
    acc  = bus.In_Valid & bus.In_Ready;
    fire = bus.Out_Valid & bus.Out_Ready;
    hold = bus.Out_Valid & ~bus.Out_Ready;
    if (fire) begin
      delivered++;
      if (sb.size() == 0) begin
        check("unexpected_output", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        g = actual();
        if (imm_dont_care(e.typ)) e.imm = g.imm;
        check("sb_decode", g, e);
        if (e.ill) ill_delivered++;
      end
    end
    if (acc) sb.push_back(model(bus.Inst_Code));
    @(posedge clk);
    #1;
    if (hold) check("hold_valid", bus.Out_Valid, 1'b1);
  endtask

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 3) != 0) w[31:26] = tbl[$urandom_range(0, 12)].w[31:26];
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] sw[4];
    logic [31:0] w;
    int k, cyc, sent;

    tbl[0]  = '{32'h00221820, 3'd0, 4'd1,  5'd3,  32'h0,        1'b1, 1'b0}; // add
    tbl[1]  = '{32'h2002FFFF, 3'd1, 4'd1,  5'd2,  32'hFFFFFFFF, 1'b1, 1'b0}; // addi
    tbl[2]  = '{32'h3402FFFF, 3'd1, 4'd4,  5'd2,  32'h0000FFFF, 1'b1, 1'b0}; // ori
    tbl[3]  = '{32'h3C021234, 3'd1, 4'd10, 5'd2,  32'h12340000, 1'b1, 1'b0}; // lui
    tbl[4]  = '{32'hFC000000, 3'd7, 4'd0,  5'd0,  32'h0,        1'b0, 1'b1}; // bad op
    tbl[5]  = '{32'h0C000010, 3'd5, 4'd0,  5'd31, 32'h0,        1'b1, 1'b0}; // jal
    tbl[6]  = '{32'h8C440008, 3'd2, 4'd1,  5'd4,  32'h00000008, 1'b1, 1'b0}; // lw
    tbl[7]  = '{32'hAC44FFFC, 3'd3, 4'd1,  5'd0,  32'hFFFFFFFC, 1'b0, 1'b0}; // sw
    tbl[8]  = '{32'h1022FFFE, 3'd4, 4'd2,  5'd0,  32'hFFFFFFFE, 1'b0, 1'b0}; // beq
    tbl[9]  = '{32'h00021080, 3'd0, 4'd8,  5'd2,  32'h0,        1'b1, 1'b0}; // sll
    tbl[10] = '{32'h00000001, 3'd7, 4'd0,  5'd0,  32'h0,        1'b0, 1'b1}; // bad funct
    tbl[11] = '{32'h28A5FFFF, 3'd1, 4'd7,  5'd5,  32'hFFFFFFFF, 1'b1, 1'b0}; // slti
    tbl[12] = '{32'h3085F0F0, 3'd1, 4'd3,  5'd5,  32'h0000F0F0, 1'b1, 1'b0}; // andi

    rst = 1'b1;
    bus.In_Valid = 1'b0;
    bus.Inst_Code = '0;
    bus.Out_Ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", bus.Out_Valid, 1'b0);
    check("rst_in_ready", bus.In_Ready, 1'b1);
    check("rst_counts", {bus.Inst_Cnt, bus.Ill_Cnt}, 32'h0);
    check("rst_fields", actual(), '0);

    // Fixed vectors: latency-1 delivery with Out_Ready held high.
    bus.Out_Ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      w = tbl[i].w;
      bus.In_Valid = 1'b1;
      bus.Inst_Code = w;
      tick();
      bus.In_Valid = 1'b0;
      check($sformatf("vec%0d_latency", i), bus.Out_Valid, 1'b1);
      check($sformatf("vec%0d_ctrl", i),
            {bus.Inst_Type, bus.ALU_Op, bus.Rd, bus.Reg_Write, bus.Illegal},
            {tbl[i].typ, tbl[i].alu, tbl[i].rd, tbl[i].rw, tbl[i].ill});
      check($sformatf("vec%0d_raw", i),
            {bus.Op, bus.Rs, bus.Rt, bus.Shamt, bus.Funct, bus.J_Addr},
            {w[31:26], w[25:21], w[20:16], w[10:6], w[5:0], w[25:0]});
      if (!imm_dont_care(tbl[i].typ))
        check($sformatf("vec%0d_imm", i), bus.Imm32, tbl[i].imm);
      tick();
    end
    check("tbl_inst_cnt", bus.Inst_Cnt, 16'd13);
    check("tbl_ill_cnt", bus.Ill_Cnt, 16'd2);

    // Stall: four words with the consumer blocked, then drain.
    sw[0] = 32'h00221820; sw[1] = 32'h2002FFFF; sw[2] = 32'h8C440008; sw[3] = 32'hFC000000;
    bus.Out_Ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6 && bus.In_Ready && k < 4; c++) begin
      bus.In_Valid = 1'b1;
      bus.Inst_Code = sw[k];
      k++;
      tick();
    end
    check("stall_accepts", k, 2);
    check("stall_in_ready", bus.In_Ready, 1'b0);
    bus.In_Valid = 1'b1;
    bus.Inst_Code = sw[k];
    tick();
    check("stall_still_blocked", {bus.In_Ready, bus.Out_Valid}, 2'b01);
    bus.Out_Ready = 1'b1;
    for (int c = 0; c < 20 && (k < 4 || sb.size() != 0); c++) begin
      bus.In_Valid = (k < 4);
      if (k < 4) bus.Inst_Code = sw[k];
      if (bus.In_Valid && bus.In_Ready) k++;
      tick();
    end
    bus.In_Valid = 1'b0;
    check("stall_drained", {k[7:0], sb.size() == 0}, {8'd4, 1'b1});
    check("stall_cnt", bus.Inst_Cnt, 16'd17);

    // Random traffic against the scoreboard.
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      bus.In_Valid = ($urandom_range(0, 3) != 0);
      bus.Inst_Code = gen_word();
      bus.Out_Ready = ($urandom_range(0, 2) != 0);
      if (bus.In_Valid && bus.In_Ready) sent++;
      tick();
      cyc++;
    end
    check("rand_no_timeout", cyc < 20000, 1'b1);
    bus.In_Valid = 1'b0;
    bus.Out_Ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() != 0; c++) tick();
    tick();
    check("rand_drained", sb.size(), 0);
    check("rand_out_idle", bus.Out_Valid, 1'b0);
    check("rand_inst_cnt", bus.Inst_Cnt, delivered % 65536);
    check("rand_ill_cnt", bus.Ill_Cnt, ill_delivered % 65536);
    check("wrap_inst_cnt4", bus4.Inst_Cnt, delivered % 16);
    check("wrap_ill_cnt4", bus4.Ill_Cnt, ill_delivered % 16);

    // Reset with both entries occupied.
    bus.Out_Ready = 1'b0;
    for (int c = 0; c < 4 && bus.In_Ready; c++) begin
      bus.In_Valid = 1'b1;
      bus.Inst_Code = tbl[c].w;
      tick();
    end
    bus.In_Valid = 1'b0;
    check("full_before_reset", {bus.In_Ready, bus.Out_Valid}, 2'b01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    delivered = 0;
    ill_delivered = 0;
    check("midrst_out_valid", bus.Out_Valid, 1'b0);
    check("midrst_in_ready", bus.In_Ready, 1'b1);
    check("midrst_counts", {bus.Inst_Cnt, bus.Ill_Cnt, bus4.Inst_Cnt, bus4.Ill_Cnt}, 40'h0);
    bus.Out_Ready = 1'b1;
    bus.In_Valid = 1'b1;
    bus.Inst_Code = 32'h8C440008;
    tick();
    bus.In_Valid = 1'b0;
    check("post_rst_latency", bus.Out_Valid, 1'b1);
    tick();
    check("post_rst_cnt", {bus.Inst_Cnt, bus.Out_Valid, sb.size() == 0}, {16'd1, 1'b0, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_translate.md
Name: inst_translate

Overview:
- Downstream of the instruction-fetch stage. Consumes the 32-bit MIPS instruction word it produces and translates it into registered decode fields and control signals for the datapath and the LED display/debug logic.
- One-cycle registered decode with a valid/ready handshake and a two-entry skid buffer, so the fetch stage can be stalled without losing instructions.
- Keeps a running count of translated and illegal instructions for board-level debug.

Parameters:
- CNT_W, 16, width of the translated-instruction and illegal-instruction counters.

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- Rst  input  1  synchronous, active-high reset
- In_Valid  input  1  Inst_Code valid from fetch
- In_Ready  output  1  block can accept Inst_Code this cycle
- Inst_Code  input  32  instruction word
- Out_Valid  output  1  decode outputs valid
- Out_Ready  input  1  consumer accepts outputs this cycle
- Op  output  6  Inst_Code[31:26]
- Rs  output  5  Inst_Code[25:21]
- Rt  output  5  Inst_Code[20:16]
- Rd  output  5  destination register: Inst_Code[15:11] for R-type; Rt for I-type writers; 31 for jal; 0 otherwise
- Shamt  output  5  Inst_Code[10:6]
- Funct  output  6  Inst_Code[5:0]
- Imm32  output  32  extended immediate, per Behaviour
- J_Addr  output  26  Inst_Code[25:0]
- Inst_Type  output  3  R, IALU, LOAD, STORE, BRANCH, JUMP, ILLEGAL
- ALU_Op  output  4  ALU operation code
- Reg_Write  output  1  instruction writes the register file
- Illegal  output  1  unsupported opcode/funct
- Inst_Cnt  output  CNT_W  instructions delivered (Out_Valid & Out_Ready)
- Ill_Cnt  output  CNT_W  illegal instructions delivered

Behaviour:
- Reset (Rst=1 at a clock edge):
  - Out_Valid=0; skid buffer emptied; In_Ready=1 in the following cycle.
  - All decode outputs 0; Inst_Cnt=0; Ill_Cnt=0.
  - Reset mid-stall discards both buffered entries.
- Handshake:
  - Accept when In_Valid & In_Ready.
  - In_Ready = ~skid_valid, driven from a register; no combinational path from Out_Ready.
  - Accepted in cycle N → Out_Valid in cycle N+1 (latency 1).
  - Outputs hold stable while Out_Valid & ~Out_Ready.
- Buffer transitions:
  - Accept, and (output empty or Out_Ready) → load output register.
  - Accept, output full, ~Out_Ready → load skid register.
  - Out_Ready & skid_valid → skid moves to output; a simultaneous accept loads the freed skid slot.
  - Out_Ready, no skid entry, no accept → Out_Valid=0.
  - Order is preserved; no drops; no duplicates.
- Decode (combinational on input, stored per entry):
  - op 0x00, funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x00 SLL, 0x02 SRL → R, Reg_Write=1.
  - op 0x08 addi (ADD, sign-ext), 0x0A slti (SLT, sign-ext), 0x0C andi / 0x0D ori / 0x0E xori (zero-ext), 0x0F lui (LUI, Imm32={imm16,16'h0}) → IALU, Reg_Write=1.
  - op 0x23 lw → LOAD, ADD, sign-ext, Reg_Write=1.
  - op 0x2B sw → STORE, ADD, sign-ext, Reg_Write=0.
  - op 0x04 beq / 0x05 bne → BRANCH, SUB, sign-ext, Reg_Write=0.
  - op 0x02 j / 0x03 jal → JUMP, Imm32=0; jal Reg_Write=1, Rd=31.
  - Anything else → ILLEGAL, Illegal=1, Reg_Write=0, ALU_Op=NOP; raw fields still passed through.
  - Rd=0 for STORE, BRANCH, j, ILLEGAL.
- Counters:
  - Increment on Out_Valid & Out_Ready; Ill_Cnt additionally requires Illegal.
  - Wrap modulo 2^CNT_W (0xFFFF → 0x0000 at default).

Decomposition:
- Package inst_translate_pkg:
  - Opcode and funct localparams.
  - Inst_Type encodings: R=0, IALU=1, LOAD=2, STORE=3, BRANCH=4, JUMP=5, ILLEGAL=7.
  - ALU_Op encodings: NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOR=6, SLT=7, SLL=8, SRL=9, LUI=10.
- One sub-module, inst_decode_comb: purely combinational word → decode bundle.
- Top holds the output register, the skid register and the counters.

Test Plan:
- Reset, then 0x00221820 (add $3,$1,$2), Out_Ready=1 → next cycle Out_Valid=1, Rs=1, Rt=2, Rd=3, Funct=0x20, Inst_Type=R, ALU_Op=ADD, Reg_Write=1; Inst_Cnt=1.
- 0x2002FFFF (addi) → Imm32=0xFFFFFFFF, Rd=2, IALU. 0x3402FFFF (ori) → Imm32=0x0000FFFF. 0x3C021234 (lui) → Imm32=0x12340000.
- 0xFC000000 → Illegal=1, Inst_Type=7, Reg_Write=0, Ill_Cnt=1. 0x0C000010 (jal) → JUMP, Rd=31, J_Addr=0x10.
- Stream 4 words with Out_Ready=0 → In_Ready drops after 2 accepts; raise Out_Ready → all 4 delivered in order, nothing lost or duplicated.
- Random In_Valid/Out_Ready over 1000 words against a scoreboard → order and decode match; Inst_Cnt equals handshakes mod 2^16.
- Assert Rst while both entries are full → next cycle Out_Valid=0, In_Ready=1, counters 0; the next word decodes correctly.
